metronome_tempo_ctrl: RTL and testbench
=======================================

Name: metronome_tempo_ctrl

Overview:
Downstream consumer of the button edge-detect stage. Takes its one-cycle reset and control-button pulses and keeps the metronome state: run/stop, tempo in BPM, beats per bar. Generates the beat tick, accent and beat-index pulses consumed by the click/LED output stages. Uses a phase accumulator, so no divider.

Parameters:
CLK_HZ, 50_000_000, input clock frequency. Accumulator full-scale FULL = 60*CLK_HZ, 32-bit minimum.
BPM_MIN, 30, lowest tempo.
BPM_MAX, 240, highest tempo, must be at most 255.
BPM_DEFAULT, 120, tempo after reset.
BEATS_MAX, 8, highest beats-per-bar, must be at most 15.
BEATS_DEFAULT, 4, beats-per-bar after reset.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_btn_reset_posedge  in  1  soft-reset pulse from the edge detector
i_control_btns_posedge  in  4  pulses: [0] start/stop toggle, [1] BPM up, [2] BPM down, [3] cycle beats-per-bar
o_bpm  out  8  current tempo
o_beats_per_bar  out  4  current beats per bar
o_running  out  1  high while the metronome runs
o_beat_tick  out  1  one-cycle pulse per beat
o_accent  out  1  one-cycle pulse, coincident with o_beat_tick when the beat index is 0
o_beat_idx  out  4  index of the most recent tick, range 0..beats-1

Behaviour:
- All outputs registered. Every input pulse takes effect on the first clock edge after it is sampled: 1-cycle latency.
- i_rst (async), or i_btn_reset_posedge (sync, highest priority), forces reset values:
  - o_bpm=BPM_DEFAULT, o_beats_per_bar=BEATS_DEFAULT.
  - o_running=0, o_beat_tick=0, o_accent=0, o_beat_idx=0, accumulator=0.
  - All other inputs in that cycle are ignored.
- FSM has two states, IDLE and RUN.
- IDLE to RUN on btn[0]:
  - Next cycle: o_running=1, o_beat_tick=1, o_accent=1, o_beat_idx=0, acc=0.
- RUN to IDLE on btn[0]:
  - Next cycle: o_running=0, acc=0, o_beat_idx=0, no tick.
- In RUN, each cycle without a tick:
  - if acc+bpm >= FULL: tick, acc <= acc+bpm-FULL.
  - else: acc <= acc+bpm.
  - Tick spacing averages FULL/bpm cycles with ±1 cycle jitter. It is exact when FULL is divisible by bpm.
- On each tick, o_beat_idx <= (idx+1 >= beats) ? 0 : idx+1. o_accent=1 when the new index is 0.
  - A stale index at or above a reduced beats value therefore wraps to 0 on the next tick.
- btn[1]: bpm+1, saturating at BPM_MAX. btn[2]: bpm-1, saturating at BPM_MIN.
  - Both in the same cycle: no change.
  - A change applies to the accumulator from the next cycle. The phase is not reset.
- btn[3]: beats <= (beats >= BEATS_MAX) ? 1 : beats+1. Does not alter the current index.
- With beats=1, every tick is an accent.
- Tempo and beats changes are accepted in both IDLE and RUN.
- Simultaneous pulses (start/stop, tempo, beats) are all applied in the same cycle.
- A start coinciding with a BPM change uses the new bpm for subsequent accumulation.
- IDLE: o_beat_tick and o_accent stay 0. The accumulator holds 0.

Test Plan:
1. Params CLK_HZ=100 (FULL=6000); assert i_rst, release -> o_bpm=120, o_beats_per_bar=4, o_running=0, no ticks for 500 cycles.
2. btn[0] pulse at cycle 10 -> o_running=1 and tick+accent (idx 0) at cycle 11. Ticks at 61/111/161 with idx 1/2/3. Tick+accent idx 0 at 211.
3. While running, 130 btn[1] pulses -> o_bpm saturates at 240 and stays. Tick spacing becomes 25 cycles.
4. 250 btn[2] pulses -> o_bpm=30, never below. Tick spacing 200 cycles. btn[1] and btn[2] in the same cycle -> o_bpm unchanged.
5. Beats 4 -> btn[3]×4 -> 5,6,7,8. Fifth press gives 1 and every tick asserts o_accent. Reduce beats from 8 while idx=6 -> next tick idx 0 with accent.
6. Mid-run, btn_reset pulse -> next cycle all outputs at reset values with bpm=120. Separately, assert i_rst between clock edges -> outputs default immediately, without waiting for i_clk. Stop via btn[0] -> o_running=0, no further ticks, idx 0.

Source files
------------

// File: rtl/metronome_tempo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : metronome_tempo_ctrl
//  Description : Metronome state keeper. Consumes one-cycle button pulses
//                (soft reset, start/stop, BPM up/down, beats-per-bar cycle)
//                and produces beat tick, accent and beat-index pulses using
//                a phase accumulator of full-scale 60*CLK_HZ.
//  Revision    : 1.0 - initial release
// ============================================================================
module metronome_tempo_ctrl #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BPM_MIN       = 30,
  parameter int unsigned BPM_MAX       = 240,
  parameter int unsigned BPM_DEFAULT   = 120,
  parameter int unsigned BEATS_MAX     = 8,
  parameter int unsigned BEATS_DEFAULT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_reset_posedge,
  input  logic [3:0] i_control_btns_posedge,
  output logic [7:0] o_bpm,
  output logic [3:0] o_beats_per_bar,
  output logic       o_running,
  output logic       o_beat_tick,
  output logic       o_accent,
  output logic [3:0] o_beat_idx
);

  // One minute worth of clock cycles; one beat elapses each time the
  // accumulator gains FULL while adding bpm per cycle.
  localparam logic [63:0] FULL_WIDE = 64'(CLK_HZ) * 64'd60;
  // Accumulator is never above FULL-1+255, so size it to hold FULL+256.
  localparam int          ACC_W     = ($clog2(FULL_WIDE + 64'd256) > 32) ?
                                      $clog2(FULL_WIDE + 64'd256) : 32;
  localparam logic [ACC_W-1:0] FULL = ACC_W'(FULL_WIDE);

  localparam logic [7:0] BPM_MIN_L       = 8'(BPM_MIN);
  localparam logic [7:0] BPM_MAX_L       = 8'(BPM_MAX);
  localparam logic [7:0] BPM_DEFAULT_L   = 8'(BPM_DEFAULT);
  localparam logic [3:0] BEATS_MAX_L     = 4'(BEATS_MAX);
  localparam logic [3:0] BEATS_DEFAULT_L = 4'(BEATS_DEFAULT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [7:0]         bpm_next;
  logic [3:0]         beats_next;
  logic [3:0]         idx_inc;
  logic [3:0]         idx_after_tick;

  // Next tempo/beats values and accumulator/index arithmetic.
  always_comb begin
    bpm_next = o_bpm;
    if (i_control_btns_posedge[1] && !i_control_btns_posedge[2] &&
        (o_bpm < BPM_MAX_L)) begin
      bpm_next = o_bpm + 8'd1;
    end else if (i_control_btns_posedge[2] && !i_control_btns_posedge[1] &&
                 (o_bpm > BPM_MIN_L)) begin
      bpm_next = o_bpm - 8'd1;
    end

    beats_next = o_beats_per_bar;
    if (i_control_btns_posedge[3]) begin
      beats_next = (o_beats_per_bar >= BEATS_MAX_L) ? 4'd1 : o_beats_per_bar + 4'd1;
    end

    // Old tempo drives this cycle's accumulation; a new one lands next cycle.
    acc_sum = acc + ACC_W'(o_bpm);

    // A stale index at/above a reduced beats count wraps to 0 here.
    idx_inc        = o_beat_idx + 4'd1;
    idx_after_tick = (idx_inc >= o_beats_per_bar) ? 4'd0 : idx_inc;
  end

  // Run/stop FSM, settings registers, accumulator and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      acc             <= '0;
      o_bpm           <= BPM_DEFAULT_L;
      o_beats_per_bar <= BEATS_DEFAULT_L;
      o_running       <= 1'b0;
      o_beat_tick     <= 1'b0;
      o_accent        <= 1'b0;
      o_beat_idx      <= 4'd0;
    end else if (i_btn_reset_posedge) begin
      state           <= ST_IDLE;
      acc             <= '0;
      o_bpm           <= BPM_DEFAULT_L;
      o_beats_per_bar <= BEATS_DEFAULT_L;
      o_running       <= 1'b0;
      o_beat_tick     <= 1'b0;
      o_accent        <= 1'b0;
      o_beat_idx      <= 4'd0;
    end else begin
      o_bpm           <= bpm_next;
      o_beats_per_bar <= beats_next;
      o_beat_tick     <= 1'b0;
      o_accent        <= 1'b0;
      case (state)
        ST_IDLE: begin
          acc <= '0;
          if (i_control_btns_posedge[0]) begin
            // Starting fires the downbeat immediately.
            state       <= ST_RUN;
            o_running   <= 1'b1;
            o_beat_tick <= 1'b1;
            o_accent    <= 1'b1;
            o_beat_idx  <= 4'd0;
          end
        end
        ST_RUN: begin
          if (i_control_btns_posedge[0]) begin
            state      <= ST_IDLE;
            o_running  <= 1'b0;
            acc        <= '0;
            o_beat_idx <= 4'd0;
          end else if (acc_sum >= FULL) begin
            acc         <= acc_sum - FULL;
            o_beat_tick <= 1'b1;
            o_accent    <= (idx_after_tick == 4'd0);
            o_beat_idx  <= idx_after_tick;
          end else begin
            acc <= acc_sum;
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_running <= 1'b0;
          acc       <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_metronome_tempo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_metronome_tempo_ctrl
//  Description : Directed self-checking bench for metronome_tempo_ctrl with
//                CLK_HZ=100 (one beat = 6000/bpm cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_metronome_tempo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_reset = 1'b0;
  logic [3:0] btns = 4'd0;
  logic [7:0] bpm;
  logic [3:0] beats;
  logic       running;
  logic       tick;
  logic       accent;
  logic [3:0] idx;

  int checks = 0;
  int errors = 0;

  metronome_tempo_ctrl #(
    .CLK_HZ(100), .BPM_MIN(30), .BPM_MAX(240), .BPM_DEFAULT(120),
    .BEATS_MAX(8), .BEATS_DEFAULT(4)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_btn_reset_posedge   (btn_reset),
    .i_control_btns_posedge(btns),
    .o_bpm                 (bpm),
    .o_beats_per_bar       (beats),
    .o_running             (running),
    .o_beat_tick           (tick),
    .o_accent              (accent),
    .o_beat_idx            (idx)
  );

  always #5 clk = ~clk;

  // One-cycle pulse; on return (a negedge) the outputs show its effect.
  task automatic pulse(input logic [3:0] b, input logic r);
    @(negedge clk);
    btns = b;
    btn_reset = r;
    @(negedge clk);
    btns = 4'd0;
    btn_reset = 1'b0;
  endtask

  // Cycles until the next tick (0 if none within max_cycles).
  task automatic wait_tick(input int max_cycles, output int n);
    n = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (tick) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic count_ticks(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tick) n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (running !== 1'b0 || tick !== 1'b0 || idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: running=%0b tick=%0b idx=%0d, required 0/0/0", running, tick, idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bpm !== 8'd120 || beats !== 4'd4 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: bpm=%0d beats=%0d running=%0b, required 120/4/0", bpm, beats, running);
    end
    count_ticks(500, n);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL idle_no_ticks: %0d ticks, required 0", n);
    end
  endtask

  task automatic test_start_ticks();
    int n;
    pulse(4'b0001, 1'b0);
    checks++;
    if (running !== 1'b1 || tick !== 1'b1 || accent !== 1'b1 || idx !== 4'd0) begin
      errors++;
      $display("FAIL start_tick: running=%0b tick=%0b accent=%0b idx=%0d, required 1/1/1/0",
               running, tick, accent, idx);
    end
    for (int k = 1; k <= 4; k++) begin
      wait_tick(200, n);
      checks++;
      if (n !== 50 || idx !== 4'(k % 4) || accent !== (k == 4)) begin
        errors++;
        $display("FAIL beat_%0d: spacing=%0d idx=%0d accent=%0b, required 50/%0d/%0b",
                 k, n, idx, accent, k % 4, (k == 4));
      end
    end
  endtask

  task automatic test_bpm_up();
    int n;
    for (int k = 0; k < 130; k++) pulse(4'b0010, 1'b0);
    checks++;
    if (bpm !== 8'd240) begin
      errors++;
      $display("FAIL bpm_sat_max: bpm=%0d, required 240", bpm);
    end
    wait_tick(300, n);
    for (int k = 0; k < 2; k++) begin
      wait_tick(300, n);
      checks++;
      if (n !== 25) begin
        errors++;
        $display("FAIL spacing_240: %0d cycles, required 25", n);
      end
    end
    pulse(4'b0010, 1'b0);
    checks++;
    if (bpm !== 8'd240) begin
      errors++;
      $display("FAIL bpm_stays_max: bpm=%0d, required 240", bpm);
    end
  endtask

  task automatic test_bpm_down();
    int n;
    for (int k = 0; k < 250; k++) pulse(4'b0100, 1'b0);
    checks++;
    if (bpm !== 8'd30) begin
      errors++;
      $display("FAIL bpm_sat_min: bpm=%0d, required 30", bpm);
    end
    wait_tick(600, n);
    wait_tick(600, n);
    checks++;
    if (n !== 200) begin
      errors++;
      $display("FAIL spacing_30: %0d cycles, required 200", n);
    end
    pulse(4'b0010, 1'b0);
    pulse(4'b0110, 1'b0);
    checks++;
    if (bpm !== 8'd31) begin
      errors++;
      $display("FAIL bpm_up_down_same: bpm=%0d, required 31", bpm);
    end
    for (int k = 0; k < 89; k++) pulse(4'b0010, 1'b0);
    checks++;
    if (bpm !== 8'd120) begin
      errors++;
      $display("FAIL bpm_back_120: bpm=%0d, required 120", bpm);
    end
  endtask

  task automatic test_beats();
    int  n;
    logic found;
    for (int k = 5; k <= 8; k++) begin
      pulse(4'b1000, 1'b0);
      checks++;
      if (beats !== 4'(k)) begin
        errors++;
        $display("FAIL beats_cycle: beats=%0d, required %0d", beats, k);
      end
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      wait_tick(200, n);
      if (n != 0 && idx == 4'd6) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL reach_idx6: idx=%0d, required 6", idx);
    end
    pulse(4'b1000, 1'b0);
    checks++;
    if (beats !== 4'd1 || idx !== 4'd6) begin
      errors++;
      $display("FAIL beats_wrap: beats=%0d idx=%0d, required 1/6", beats, idx);
    end
    for (int k = 0; k < 3; k++) begin
      wait_tick(200, n);
      checks++;
      if (n == 0 || idx !== 4'd0 || accent !== 1'b1) begin
        errors++;
        $display("FAIL beats1_accent: spacing=%0d idx=%0d accent=%0b, required tick/0/1", n, idx, accent);
      end
    end
  endtask

  task automatic test_stop();
    int n;
    wait_tick(200, n);
    pulse(4'b0001, 1'b0);
    checks++;
    if (running !== 1'b0 || tick !== 1'b0 || idx !== 4'd0) begin
      errors++;
      $display("FAIL stop: running=%0b tick=%0b idx=%0d, required 0/0/0", running, tick, idx);
    end
    count_ticks(300, n);
    checks++;
    if (n !== 0 || running !== 1'b0) begin
      errors++;
      $display("FAIL stopped_quiet: ticks=%0d running=%0b, required 0/0", n, running);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // Start together with BPM down: 119 bpm gives 51 cycles (120 would give 50).
    pulse(4'b0101, 1'b0);
    checks++;
    if (running !== 1'b1 || tick !== 1'b1 || bpm !== 8'd119) begin
      errors++;
      $display("FAIL start_with_down: running=%0b tick=%0b bpm=%0d, required 1/1/119", running, tick, bpm);
    end
    wait_tick(200, n);
    checks++;
    if (n !== 51 || accent !== 1'b1 || idx !== 4'd0) begin
      errors++;
      $display("FAIL spacing_119: spacing=%0d accent=%0b idx=%0d, required 51/1/0", n, accent, idx);
    end
  endtask

  task automatic test_soft_reset();
    int n;
    repeat (7) @(negedge clk);
    pulse(4'b1011, 1'b1);
    checks++;
    if (bpm !== 8'd120 || beats !== 4'd4 || running !== 1'b0 || tick !== 1'b0 ||
        accent !== 1'b0 || idx !== 4'd0) begin
      errors++;
      $display("FAIL soft_reset: bpm=%0d beats=%0d run=%0b tick=%0b acc=%0b idx=%0d, required 120/4/0/0/0/0",
               bpm, beats, running, tick, accent, idx);
    end
    count_ticks(300, n);
    checks++;
    if (n !== 0 || running !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset_quiet: ticks=%0d running=%0b, required 0/0", n, running);
    end
  endtask

  task automatic test_async_reset();
    pulse(4'b0011, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (running !== 1'b1 || bpm !== 8'd121) begin
      errors++;
      $display("FAIL pre_async: running=%0b bpm=%0d, required 1/121", running, bpm);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (running !== 1'b0 || bpm !== 8'd120 || beats !== 4'd4 || idx !== 4'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: running=%0b bpm=%0d beats=%0d idx=%0d tick=%0b, required 0/120/4/0/0",
               running, bpm, beats, idx, tick);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL after_async: running=%0b tick=%0b, required 0/0", running, tick);
    end
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_bpm_up();
    test_bpm_down();
    test_beats();
    test_stop();
    test_back_to_back();
    test_soft_reset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
